// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file ALU sequencer:
//   - default operand/result and register-select widths
//   - ALU opcode encoding (op_e)
//   - sequencer FSM state encoding (state_e)
// No ports; imported by the interface, the ALU and the sequencer top.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLL  = 3'b101,
        OP_SRL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EXEC    = 3'd3,
        WRITE   = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_alu_sequencer_if
// Bundles the command handshake, the register-file read/write port and the
// result/status outputs of the sequencer.
//   master : command issuer / register file side (drives commands, read data)
//   slave  : sequencer side (drives ready, register-file strobes, results)
// Signals:
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_rs1/cmd_rs2/cmd_rd  - command
//   rf_RD, rf_sel_o1, rf_sel_o2, rf_op1, rf_op2               - operand read
//   rf_WR, rf_sel_i, rf_ip                                    - write-back
//   result, zero, carry, done                                 - status
// -----------------------------------------------------------------------------
interface regfile_alu_sequencer_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_rs1;
    logic [ADDR_WIDTH-1:0] cmd_rs2;
    logic [ADDR_WIDTH-1:0] cmd_rd;

    logic                  rf_RD;
    logic [ADDR_WIDTH-1:0] rf_sel_o1;
    logic [ADDR_WIDTH-1:0] rf_sel_o2;
    logic [DATA_WIDTH-1:0] rf_op1;
    logic [DATA_WIDTH-1:0] rf_op2;

    logic                  rf_WR;
    logic [ADDR_WIDTH-1:0] rf_sel_i;
    logic [DATA_WIDTH-1:0] rf_ip;

    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  carry;
    logic                  done;

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rf_op1, rf_op2,
        input  cmd_ready, rf_RD, rf_sel_o1, rf_sel_o2, rf_WR, rf_sel_i, rf_ip,
               result, zero, carry, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rf_op1, rf_op2,
        output cmd_ready, rf_RD, rf_sel_o1, rf_sel_o2, rf_WR, rf_sel_i, rf_ip,
               result, zero, carry, done
    );

endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU.
// Ports:
//   op1, op2 [DATA_WIDTH-1:0] in  - operands
//   op       op_e             in  - operation select
//   result   [DATA_WIDTH-1:0] out - operation result, modulo 2^DATA_WIDTH
//   carry                     out - ADD carry-out, SUB borrow, else 0
// Shifts use the low $clog2(DATA_WIDTH) bits of op2 and zero-fill.
// -----------------------------------------------------------------------------
module alu_core
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  op_e                   op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);

    localparam int SHAMT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [SHAMT_W-1:0]    shamt;

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        sum    = {1'b0, op1} + {1'b0, op2};
        // The extra MSB of an unsigned subtraction is 1 exactly when op1 < op2.
        diff   = {1'b0, op1} - {1'b0, op2};
        shamt  = op2[SHAMT_W-1:0];
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  begin result = sum[DATA_WIDTH-1:0];  carry = sum[DATA_WIDTH];  end
            OP_SUB:  begin result = diff[DATA_WIDTH-1:0]; carry = diff[DATA_WIDTH]; end
            OP_AND:  result = op1 & op2;
            OP_OR:   result = op1 | op2;
            OP_XOR:  result = op1 ^ op2;
            OP_SLL:  result = op1 << shamt;
            OP_SRL:  result = op1 >> shamt;
            OP_PASS: result = op1;
        endcase
    end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_alu_sequencer
// Accepts one ALU command at a time and runs it against an external register
// file in five cycles: IDLE -> READ -> CAPTURE -> EXEC -> WRITE -> IDLE.
// Ports:
//   clk  in  - sole clock, rising edge
//   rst  in  - asynchronous, active-low reset
//   en   in  - global enable; low freezes the sequencer and drops all strobes
//   bus  slave modport of regfile_alu_sequencer_if (command, register-file
//        read/write port, result/zero/carry/done)
// -----------------------------------------------------------------------------
module regfile_alu_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    regfile_alu_sequencer_if.slave  bus
);

    state_e                state_q;
    state_e                state_d;
    logic                  run_q;
    logic                  cmd_ready_c;
    logic                  accept;

    op_e                   op_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;

    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  carry_q;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;

    // run_q holds ready low through reset and rises on the first clock after
    // release, so a reset can never coincide with a command acceptance.
    assign cmd_ready_c = en && run_q && (state_q == IDLE);
    assign accept      = cmd_ready_c && bus.cmd_valid;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (en && state_q == EXEC) begin
                result_q <= alu_result;
                zero_q   <= (alu_result == '0);
                carry_q  <= alu_carry;
            end
        end
    end

    // NOTE: the latched command and operands carry no reset: each is written
    // before it is consumed, and all outputs derived from them are gated by
    // the state, which is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_e'(bus.cmd_op);
            rs1_q <= bus.cmd_rs1;
            rs2_q <= bus.cmd_rs2;
            rd_q  <= bus.cmd_rd;
        end
        if (en && state_q == CAPTURE) begin
            op1_q <= bus.rf_op1;
            op2_q <= bus.rf_op2;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE:    if (accept) state_d = READ;
                READ:    state_d = CAPTURE;
                CAPTURE: state_d = EXEC;
                EXEC:    state_d = WRITE;
                WRITE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cmd_ready = cmd_ready_c;
        bus.rf_RD     = 1'b0;
        bus.rf_sel_o1 = '0;
        bus.rf_sel_o2 = '0;
        bus.rf_WR     = 1'b0;
        bus.rf_sel_i  = '0;
        bus.rf_ip     = '0;
        bus.done      = 1'b0;
        if (en && state_q == READ) begin
            bus.rf_RD     = 1'b1;
            bus.rf_sel_o1 = rs1_q;
            bus.rf_sel_o2 = rs2_q;
        end
        if (en && state_q == WRITE) begin
            bus.rf_WR    = 1'b1;
            bus.rf_sel_i = rd_q;
            bus.rf_ip    = result_q;
            bus.done     = 1'b1;
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op1    (op1_q),
        .op2    (op2_q),
        .op     (op_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

endmodule

// File: doc/regfile_alu_sequencer.md
REGFILE_ALU_SEQUENCER -- requirements
Module: regfile_alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-select width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  global enable; low freezes FSM.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted this edge when cmd_valid=1.
REQ-009 cmd_op  in  3  opcode.
REQ-010 cmd_rs1, cmd_rs2, cmd_rd  in  ADDR_WIDTH each  source and destination registers.
REQ-011 rf_RD  out  1  register-file read enable.
REQ-012 rf_sel_o1, rf_sel_o2  out  ADDR_WIDTH each  read selects.
REQ-013 rf_op1, rf_op2  in  DATA_WIDTH each  read data, valid one cycle after rf_RD.
REQ-014 rf_WR  out  1  register-file write enable.
REQ-015 rf_sel_i  out  ADDR_WIDTH  write select.
REQ-016 rf_ip  out  DATA_WIDTH  write data.
REQ-017 result  out  DATA_WIDTH  last computed value.
REQ-018 zero, carry  out  1 each  flags of last result.
REQ-019 done  out  1  one-cycle pulse in write-back cycle.

Function
REQ-020 FSM states SHALL be IDLE, READ, CAPTURE, EXEC, WRITE.
REQ-021 cmd_ready SHALL be 1 only when state=IDLE and en=1.
REQ-022 On accept at edge N: command latched; READ during cycle N+1, CAPTURE N+2, EXEC N+3, WRITE N+4, IDLE N+5 (5-cycle throughput, one command in flight).
REQ-023 READ: rf_RD=1, rf_sel_o1=rs1, rf_sel_o2=rs2; rf_RD=0 in all other states.
REQ-024 CAPTURE: rf_op1/rf_op2 registered at end of cycle.
REQ-025 EXEC: ALU result and flags registered into result/zero/carry at end of cycle.
REQ-026 WRITE: rf_WR=1, rf_sel_i=rd, rf_ip=result, done=1; all three 0 elsewhere.
REQ-027 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 PASS(op1).
REQ-028 Arithmetic modulo 2^DATA_WIDTH; ADD carry=carry-out; SUB carry=borrow (op1<op2 unsigned); logic/shift/PASS carry=0.
REQ-029 Shift amount = low $clog2(DATA_WIDTH) bits of op2; zero-fill.
REQ-030 zero=1 iff registered result==0.
REQ-031 rd equal to rs1/rs2 SHALL be legal; operands read before write-back.
REQ-032 en=0 in any state: state, latched command, operands, result held; rf_RD, rf_WR, done, cmd_ready forced 0; resumes in same state when en=1.
REQ-033 cmd_valid while not ready: ignored, no side effect.

Reset
REQ-034 rst=0 SHALL immediately force state=IDLE, result=0, zero=0, carry=0, done=0, rf_RD=0, rf_WR=0, all selects and rf_ip=0, cmd_ready=0.
REQ-035 Reset mid-command SHALL abort it with no register-file write.

Structure
REQ-036 Shared package regfile_pkg SHALL hold opcode constants, FSM state encoding, default DATA_WIDTH/ADDR_WIDTH.
REQ-037 Combinational ALU SHALL be sub-module alu_core (op1, op2, op -> result, carry).

Verification (bench connects the existing RegisterFile, DATA_WIDTH=32, ADDR_WIDTH=4)
REQ-038 rst=0, en=1 -> all outputs 0, cmd_ready=0; rst=1 -> cmd_ready=1 next cycle.
REQ-039 R0=FFFF_FFFF, R1=0000_0001; ADD rs1=0 rs2=1 rd=2 -> rf_WR, sel_i=2, rf_ip=0 at N+4, zero=1, carry=1, done one cycle; R2 reads 0.
REQ-040 R3=5, R4=7; SUB rd=5 -> result FFFF_FFFE, carry=1, zero=0; SLL R3 by R4 -> 0000_0280.
REQ-041 cmd_valid held high for two commands -> cmd_ready low N+1..N+4; second accepted at N+5.
REQ-042 en=0 for 3 cycles during CAPTURE -> no strobes, done delayed exactly 3 cycles, result correct.
REQ-043 rst=0 asserted during EXEC of ADD into R6=1234_5678 -> rf_WR never asserted, R6 remains 1234_5678.
